// File: rtl/ram16k_arbiter_pkg.sv
// Shared constants and enumerations for the RAM16k arbiter and its round-robin sub-arbiter.
package ram16k_arbiter_pkg;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 16;
   localparam int RAM_DEPTH = 16384;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; req[0]/gnt[0] is port A, req[1]/gnt[1] is port B.
module rr_arb2
   import ram16k_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       enable,
   output logic [1:0] gnt
);

   owner_t ptr;

   always_comb begin
      gnt = 2'b00;
      if (enable) begin
         if (req == 2'b11) begin
            gnt = (ptr == OWN_A) ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
   end

   // The pointer only advances when both ports contend; a lone requester leaves it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= OWN_A;
      end else if (enable && (req == 2'b11)) begin
         ptr <= (ptr == OWN_A) ? OWN_B : OWN_A;
      end
   end

endmodule

// File: rtl/ram16k_arbiter.sv
// Shares one RAM16k between ports A and B with round-robin grants, a registered
// command stage, a registered read-return stage and a whole-memory clear sequencer.
module ram16k_arbiter
   import ram16k_arbiter_pkg::*;
#(
   parameter logic [DATA_W-1:0] CLEAR_VALUE = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] ram_sel,
   output logic [DATA_W-1:0] ram_in,
   output logic              ram_load,
   input  logic [DATA_W-1:0] ram_out
);

   state_t            state;
   state_t            state_next;
   owner_t            owner;
   logic              rd_pend;
   logic [ADDR_W-1:0] clr_cnt;
   logic [1:0]        gnt;
   logic              arb_en;
   logic              clear_last;

   // Gating on rst keeps the combinational grants at zero while reset is held.
   assign arb_en     = (state == ST_RUN) && !clr_start && !rst;
   assign clear_last = ram_load && (ram_sel == LAST_ADDR);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({b_req, a_req}),
      .enable (arb_en),
      .gnt    (gnt)
   );

   assign a_gnt = gnt[0];
   assign b_gnt = gnt[1];

   always_comb begin
      state_next = state;
      if (state == ST_RUN) begin
         if (clr_start) begin
            state_next = ST_CLEAR;
         end
      end else if (clear_last) begin
         state_next = ST_RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Command stage and clear walk; the counter runs one address ahead of ram_sel
   // and saturates at the last address so it never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_sel  <= '0;
         ram_in   <= '0;
         ram_load <= 1'b0;
         owner    <= OWN_A;
         rd_pend  <= 1'b0;
         clr_cnt  <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         rd_pend  <= 1'b0;
         if (state == ST_CLEAR) begin
            if (clear_last) begin
               ram_load <= 1'b0;
               clr_busy <= 1'b0;
               clr_done <= 1'b1;
            end else begin
               ram_sel <= clr_cnt;
               if (clr_cnt != LAST_ADDR) begin
                  clr_cnt <= clr_cnt + ADDR_W'(1);
               end
            end
         end else if (clr_start) begin
            ram_sel  <= '0;
            ram_in   <= CLEAR_VALUE;
            ram_load <= 1'b1;
            clr_cnt  <= ADDR_W'(1);
            clr_busy <= 1'b1;
         end else if (gnt[0]) begin
            ram_sel  <= a_addr;
            ram_in   <= a_wdata;
            ram_load <= a_we;
            owner    <= OWN_A;
            rd_pend  <= ~a_we;
         end else if (gnt[1]) begin
            ram_sel  <= b_addr;
            ram_in   <= b_wdata;
            ram_load <= b_we;
            owner    <= OWN_B;
            rd_pend  <= ~b_we;
         end else begin
            ram_load <= 1'b0;
         end
      end
   end

   // Read return captures the RAM output during the cycle after the command was registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_rdata  <= '0;
         b_rdata  <= '0;
      end else begin
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         if (rd_pend) begin
            if (owner == OWN_A) begin
               a_rvalid <= 1'b1;
               a_rdata  <= ram_out;
            end else begin
               b_rvalid <= 1'b1;
               b_rdata  <= ram_out;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Self-checking bench: behavioural model (grant-ordered memory, return queue, clear countdown)
// compared every cycle, plus directed scenarios with literal expectations.
module tb_ram16k_arbiter;

   localparam int DEPTH = 16384;
   localparam logic [15:0] CLR_VAL = 16'h0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        a_req = 1'b0, a_we = 1'b0;
   logic [13:0] a_addr = '0;
   logic [15:0] a_wdata = '0;
   logic        b_req = 1'b0, b_we = 1'b0;
   logic [13:0] b_addr = '0;
   logic [15:0] b_wdata = '0;
   logic        clr_start = 1'b0;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [15:0] a_rdata, b_rdata;
   logic        clr_busy, clr_done;
   logic [13:0] ram_sel;
   logic [15:0] ram_in;
   logic        ram_load;
   logic [15:0] ram_out;

   int pass_cnt = 0;
   int total_cnt = 0;

   ram16k_arbiter #(.CLEAR_VALUE(CLR_VAL)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
      .ram_sel(ram_sel), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
   );

   always #5 clk = ~clk;

   // RAM16k stand-in: synchronous write on load, combinational read.
   logic [15:0] mem [DEPTH];
   assign ram_out = mem[ram_sel];
   always @(posedge clk) if (ram_load) mem[ram_sel] <= ram_in;

   typedef struct {
      bit          port;
      logic [15:0] data;
   } ret_t;

   logic [15:0] ref_mem [DEPTH];
   ret_t        rq[$];
   ret_t        m_r;
   int          busy_left = 0;
   bit          ptr = 1'b0;
   logic        e_a_rvalid = 0, e_b_rvalid = 0, e_busy = 0, e_done = 0, e_load = 0;
   logic [15:0] e_a_rdata = 0, e_b_rdata = 0;
   logic [1:0]  m_g, c_g;
   bit          m_we;
   logic [13:0] m_addr;
   logic [15:0] m_wdata;
   bit          run_checks = 1'b0;
   bit          ga = 1'b0, gb = 1'b0;
   int          n, busy_cnt;
   logic [13:0] pool [8];
   logic [13:0] b_list [3];
   logic [15:0] b_exp [3];

   function automatic logic [1:0] model_gnt();
      if (rst || busy_left != 0 || clr_start) return 2'b00;
      if (a_req && b_req) return ptr ? 2'b10 : 2'b01;
      if (a_req) return 2'b01;
      if (b_req) return 2'b10;
      return 2'b00;
   endfunction

   // Ops take effect in grant order; a read sees every earlier write and returns two cycles later.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr = 1'b0; busy_left = 0; rq.delete();
         e_a_rvalid = 0; e_b_rvalid = 0; e_a_rdata = 0; e_b_rdata = 0;
         e_busy = 0; e_done = 0; e_load = 0;
      end else begin
         m_g = model_gnt();
         e_a_rvalid = 0; e_b_rvalid = 0; e_done = 0;
         if (rq.size() > 0) begin
            m_r = rq.pop_front();
            if (m_r.port) begin e_b_rvalid = 1; e_b_rdata = m_r.data; end
            else begin e_a_rvalid = 1; e_a_rdata = m_r.data; end
         end
         if (busy_left > 0) begin
            ref_mem[DEPTH - busy_left] = CLR_VAL;
            busy_left--;
            if (busy_left == 0) begin e_busy = 0; e_done = 1; e_load = 0; end
         end else if (clr_start) begin
            busy_left = DEPTH; e_busy = 1; e_load = 1;
         end else begin
            e_load = 0;
            if (m_g != 2'b00) begin
               m_we    = m_g[1] ? b_we : a_we;
               m_addr  = m_g[1] ? b_addr : a_addr;
               m_wdata = m_g[1] ? b_wdata : a_wdata;
               if (m_we) begin
                  ref_mem[m_addr] = m_wdata;
                  e_load = 1;
               end else begin
                  rq.push_back('{m_g[1], ref_mem[m_addr]});
               end
               if (a_req && b_req) ptr = ~ptr;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      total_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
   endtask

   always @(negedge clk) begin
      if (run_checks) begin
         c_g = model_gnt();
         checkOutput("a_gnt", 16'(a_gnt), 16'(c_g[0]));
         checkOutput("b_gnt", 16'(b_gnt), 16'(c_g[1]));
         checkOutput("a_rvalid", 16'(a_rvalid), 16'(e_a_rvalid));
         checkOutput("b_rvalid", 16'(b_rvalid), 16'(e_b_rvalid));
         checkOutput("a_rdata", a_rdata, e_a_rdata);
         checkOutput("b_rdata", b_rdata, e_b_rdata);
         checkOutput("clr_busy", 16'(clr_busy), 16'(e_busy));
         checkOutput("clr_done", 16'(clr_done), 16'(e_done));
         checkOutput("ram_load", 16'(ram_load), 16'(e_load));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds one request until granted, then withdraws it; returns one cycle after the grant.
   task automatic applyStimulus(input bit port, input bit we, input logic [13:0] addr, input logic [15:0] wdata);
      bit got = 1'b0;
      if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
      else begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
      for (int k = 0; k < 32 && !got; k++) begin
         #1;
         got = port ? b_gnt : a_gnt;
         tick();
      end
      if (port) b_req = 0; else a_req = 0;
      checkOutput("grant", 16'(got), 16'h1);
   endtask

   task automatic readCheck(input string name, input bit port, input logic [13:0] addr, input logic [15:0] exp);
      applyStimulus(port, 1'b0, addr, 16'h0);
      tick();
      if (port) begin
         checkOutput({name, "_rvalid"}, 16'(b_rvalid), 16'h1);
         checkOutput({name, "_rdata"}, b_rdata, exp);
      end else begin
         checkOutput({name, "_rvalid"}, 16'(a_rvalid), 16'h1);
         checkOutput({name, "_rdata"}, a_rdata, exp);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, pass %0d total %0d", pass_cnt, total_cnt);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1;
      run_checks = 1;
      repeat (3) tick();
      rst = 0;
      tick();
      checkOutput("rst_clr_busy", 16'(clr_busy), 16'h0);
      checkOutput("rst_ram_load", 16'(ram_load), 16'h0);
      checkOutput("rst_ram_sel", 16'(ram_sel), 16'h0);
      checkOutput("rst_a_rdata", a_rdata, 16'h0);

      $display("[TB] write then read on port A");
      applyStimulus(1'b0, 1'b1, 14'h2E3B, 16'hDEAF);
      tick();
      readCheck("t1", 1'b0, 14'h2E3B, 16'hDEAF);
      checkOutput("t1_b_rvalid", 16'(b_rvalid), 16'h0);

      $display("[TB] both ports contend every cycle");
      a_req = 1; a_we = 1; a_addr = 14'h388C; a_wdata = 16'hC0DE;
      b_req = 1; b_we = 0; b_addr = 14'h388C;
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("alt_a_gnt", 16'(a_gnt), 16'(i % 2 == 0));
         checkOutput("alt_b_gnt", 16'(b_gnt), 16'(i % 2 == 1));
         if (i == 3) begin
            checkOutput("alt_b_rvalid", 16'(b_rvalid), 16'h1);
            checkOutput("alt_b_rdata", b_rdata, 16'hC0DE);
         end
         tick();
      end
      a_req = 0; b_req = 0;
      repeat (3) tick();

      $display("[TB] back-to-back write then read");
      applyStimulus(1'b0, 1'b1, 14'h0000, 16'h1234);
      checkOutput("b2b_load_c1", 16'(ram_load), 16'h1);
      applyStimulus(1'b0, 1'b0, 14'h0000, 16'h0);
      checkOutput("b2b_load_c2", 16'(ram_load), 16'h0);
      tick();
      checkOutput("b2b_rvalid", 16'(a_rvalid), 16'h1);
      checkOutput("b2b_rdata", a_rdata, 16'h1234);
      tick();

      $display("[TB] port B alone, three reads");
      b_list = '{14'h2E3B, 14'h388C, 14'h0000};
      b_exp  = '{16'hDEAF, 16'hC0DE, 16'h1234};
      for (int i = 0; i < 5; i++) begin
         if (i < 3) begin b_req = 1; b_we = 0; b_addr = b_list[i]; end
         else b_req = 0;
         #1;
         if (i < 3) checkOutput("bonly_gnt", 16'(b_gnt), 16'h1);
         if (i >= 2) begin
            checkOutput("bonly_rvalid", 16'(b_rvalid), 16'h1);
            checkOutput("bonly_rdata", b_rdata, b_exp[i-2]);
         end
         tick();
      end
      tick();

      $display("[TB] full clear");
      applyStimulus(1'b0, 1'b1, 14'h0000, 16'hFFFF);
      applyStimulus(1'b0, 1'b1, 14'h1000, 16'hFFFF);
      applyStimulus(1'b0, 1'b1, 14'h3FFF, 16'hFFFF);
      tick();
      clr_start = 1; b_req = 1; b_we = 0; b_addr = 14'h1000;
      n = 0; busy_cnt = 0;
      #1;
      checkOutput("clr_start_blocks_b", 16'(b_gnt), 16'h0);
      while (!b_gnt && n < 17000) begin
         if (clr_busy) busy_cnt++;
         tick();
         clr_start = 0;
         n++;
         #1;
      end
      checkOutput("clr_nogrant_cycles", 16'(n), 16'd16385);
      checkOutput("clr_busy_cycles", 16'(busy_cnt), 16'd16384);
      checkOutput("clr_done_pulse", 16'(clr_done), 16'h1);
      tick();
      b_req = 0;
      tick();
      checkOutput("clr_b_rvalid", 16'(b_rvalid), 16'h1);
      checkOutput("clr_b_rdata", b_rdata, 16'h0000);
      readCheck("clr_0000", 1'b0, 14'h0000, 16'h0000);
      readCheck("clr_3fff", 1'b0, 14'h3FFF, 16'h0000);

      $display("[TB] reset during clear");
      applyStimulus(1'b0, 1'b1, 14'h0200, 16'hA5A5);
      applyStimulus(1'b0, 1'b1, 14'h0050, 16'h5A5A);
      tick();
      clr_start = 1;
      tick();
      clr_start = 0;
      repeat (256) tick();
      checkOutput("abort_sel_before", 16'(ram_sel), 16'h0100);
      rst = 1;
      #1;
      checkOutput("abort_busy", 16'(clr_busy), 16'h0);
      checkOutput("abort_load", 16'(ram_load), 16'h0);
      checkOutput("abort_sel", 16'(ram_sel), 16'h0);
      checkOutput("abort_done", 16'(clr_done), 16'h0);
      tick();
      tick();
      rst = 0;
      tick();
      readCheck("abort_0200", 1'b0, 14'h0200, 16'hA5A5);
      readCheck("abort_0050", 1'b0, 14'h0050, 16'h0000);

      $display("[TB] randomized traffic");
      pool = '{14'h0000, 14'h0001, 14'h0050, 14'h0200, 14'h1000, 14'h2E3B, 14'h388C, 14'h3FFF};
      ga = 0; gb = 0;
      for (int c = 0; c < 1500; c++) begin
         if (!a_req || ga) begin
            a_req = ($urandom_range(0, 3) != 0);
            a_we = 1'($urandom);
            a_addr = pool[$urandom_range(0, 7)];
            a_wdata = 16'($urandom);
         end else if ($urandom_range(0, 15) == 0) a_req = 0;
         if (!b_req || gb) begin
            b_req = ($urandom_range(0, 3) != 0);
            b_we = 1'($urandom);
            b_addr = pool[$urandom_range(0, 7)];
            b_wdata = 16'($urandom);
         end else if ($urandom_range(0, 15) == 0) b_req = 0;
         #1;
         ga = a_gnt;
         gb = b_gnt;
         tick();
      end
      a_req = 0; b_req = 0;
      repeat (4) tick();
      run_checks = 0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
